// File: rtl/sprite_fetch_sched.sv
// Per-scanline sprite row fetch scheduler: checks each sprite against the next
// scanline, fetches 4 bitmap bytes per hit into shadow rows, then commits all
// rows atomically at the end of the line.
module sprite_fetch_sched #(
    parameter int NSPR = 2,
    parameter int ROWS = 32
) (
    input  logic                 CLK,
    input  logic                 Rst_n,
    input  logic                 LineStart,
    input  logic [9:0]           YNext,
    input  logic [10*NSPR-1:0]   SprY,
    input  logic [NSPR-1:0]      SprEn,
    output logic                 MemReq,
    output logic [2:0]           MemSel,
    output logic [6:0]           MemAddr,
    input  logic [7:0]           MemData,
    output logic [32*NSPR-1:0]   RowBits,
    output logic [NSPR-1:0]      RowValid,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Overrun
);

    localparam logic [2:0]  LAST   = 3'(NSPR - 1);
    localparam logic [10:0] ROWS_W = 11'(ROWS);

    typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q;
    logic [1:0]          word_q;
    logic [4:0]          ys_q;
    logic [9:0]          ynext_q;
    logic [10*NSPR-1:0]  spry_q;
    logic [NSPR-1:0]     spren_q;
    logic                cap_vld_q;
    logic [2:0]          cap_idx_q;
    logic [1:0]          cap_word_q;
    logic [32*NSPR-1:0]  shadow_q, shadow_d;
    logic [NSPR-1:0]     shvld_q, shvld_d;
    logic [32*NSPR-1:0]  rowbits_q;
    logic [NSPR-1:0]     rowvld_q;
    logic                done_q, overrun_q;

    logic [9:0]          ysel, ys_cur;
    logic                esel, hit, last;

    // Select the current sprite's latched Y/enable and evaluate the line hit
    always_comb begin
        ysel = '0;
        esel = 1'b0;
        for (int unsigned i = 0; i < NSPR; i++) begin
            if (idx_q == 3'(i)) begin
                ysel = spry_q[10*i +: 10];
                esel = spren_q[i];
            end
        end
        ys_cur = ynext_q - ysel;
        hit    = esel && ({1'b0, ys_cur} < ROWS_W);
        last   = (idx_q == LAST);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a LineStart in any state (re)starts at sprite 0
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = IDLE;
            CHECK: state_d = hit ? FETCH : (last ? DRAIN : CHECK);
            FETCH: state_d = (word_q == 2'd3) ? (last ? DRAIN : CHECK) : FETCH;
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (LineStart) state_d = CHECK;
    end

    // Output decode: memory strobe only in FETCH, select/address zeroed otherwise
    always_comb begin
        MemReq  = (state_q == FETCH);
        MemSel  = '0;
        MemAddr = '0;
        if (MemReq) begin
            MemSel  = idx_q;
            MemAddr = {ys_q, word_q};
        end
        Busy = (state_q != IDLE);
    end

    // Shadow update: capture returning bytes, clear rows of missed sprites.
    // A LineStart suppresses both so nothing from an aborted line lands.
    always_comb begin
        shadow_d = shadow_q;
        shvld_d  = shvld_q;
        if (!LineStart) begin
            for (int unsigned i = 0; i < NSPR; i++) begin
                for (int unsigned w = 0; w < 4; w++) begin
                    if (cap_vld_q && cap_idx_q == 3'(i) && cap_word_q == 2'(w))
                        shadow_d[32*i + 24 - 8*w +: 8] = MemData;
                end
                if (state_q == CHECK && idx_q == 3'(i)) begin
                    shvld_d[i] = hit;
                    if (!hit) shadow_d[32*i +: 32] = '0;
                end
            end
        end
    end

    // Datapath registers: input latches, sprite/word counters, capture pipe, commit
    always_ff @(posedge CLK) begin
        if (!Rst_n) begin
            idx_q      <= '0;
            word_q     <= '0;
            ys_q       <= '0;
            ynext_q    <= '0;
            spry_q     <= '0;
            spren_q    <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            cap_word_q <= '0;
            shadow_q   <= '0;
            shvld_q    <= '0;
            rowbits_q  <= '0;
            rowvld_q   <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            shadow_q   <= shadow_d;
            shvld_q    <= shvld_d;
            cap_vld_q  <= MemReq && !LineStart;
            cap_idx_q  <= idx_q;
            cap_word_q <= word_q;
            if (LineStart) begin
                ynext_q   <= YNext;
                spry_q    <= SprY;
                spren_q   <= SprEn;
                idx_q     <= '0;
                word_q    <= '0;
                overrun_q <= (state_q != IDLE);
            end else begin
                unique case (state_q)
                    CHECK: begin
                        word_q <= '0;
                        if (hit)       ys_q  <= ys_cur[4:0];
                        else if (!last) idx_q <= idx_q + 3'd1;
                    end
                    FETCH: begin
                        word_q <= word_q + 2'd1;
                        if (word_q == 2'd3 && !last) idx_q <= idx_q + 3'd1;
                    end
                    // The final byte lands in DRAIN, so commit the next-shadow value
                    DRAIN: begin
                        rowbits_q <= shadow_d;
                        rowvld_q  <= shvld_d;
                        done_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RowBits  = rowbits_q;
    assign RowValid = rowvld_q;
    assign Done     = done_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Directed testbench for sprite_fetch_sched (NSPR=2, ROWS=32) with a
// behavioural bitmap memory returning data one cycle after each request.
module tb_sprite_fetch_sched;

    logic        CLK = 1'b0;
    logic        Rst_n = 1'b0;
    logic        LineStart = 1'b0;
    logic [9:0]  YNext = '0;
    logic [19:0] SprY = '0;
    logic [1:0]  SprEn = '0;
    logic        MemReq;
    logic [2:0]  MemSel;
    logic [6:0]  MemAddr;
    logic [7:0]  MemData = '0;
    logic [63:0] RowBits;
    logic [1:0]  RowValid;
    logic        Busy, Done, Overrun;

    int checks = 0;
    int errors = 0;

    logic        tr_req  [0:31];
    logic [2:0]  tr_sel  [0:31];
    logic [6:0]  tr_addr [0:31];
    logic        tr_done [0:31];
    logic        tr_ovr  [0:31];
    logic        tr_busy [0:31];
    logic [63:0] tr_rb   [0:31];
    logic [1:0]  tr_rv   [0:31];

    sprite_fetch_sched #(.NSPR(2), .ROWS(32)) dut (
        .CLK(CLK), .Rst_n(Rst_n), .LineStart(LineStart), .YNext(YNext),
        .SprY(SprY), .SprEn(SprEn), .MemReq(MemReq), .MemSel(MemSel),
        .MemAddr(MemAddr), .MemData(MemData), .RowBits(RowBits),
        .RowValid(RowValid), .Busy(Busy), .Done(Done), .Overrun(Overrun)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_byte(input logic [2:0] s, input logic [6:0] a);
        logic [7:0] v;
        v = {1'b0, a} * 8'd3;
        return v ^ {s, 5'd0} ^ 8'h3C;
    endfunction

    function automatic logic [31:0] exp_row(input logic [2:0] s, input logic [6:0] a);
        return {mem_byte(s, a), mem_byte(s, a + 7'd1), mem_byte(s, a + 7'd2), mem_byte(s, a + 7'd3)};
    endfunction

    // Bitmap memory: data valid the cycle after the request
    always @(posedge CLK) MemData <= MemReq ? mem_byte(MemSel, MemAddr) : 8'h00;

    task automatic record(input int k);
        tr_req[k] = MemReq;   tr_sel[k] = MemSel;   tr_addr[k] = MemAddr;
        tr_done[k] = Done;    tr_ovr[k] = Overrun;  tr_busy[k] = Busy;
        tr_rb[k] = RowBits;   tr_rv[k] = RowValid;
    endtask

    // LineStart in cycle 0; optional second LineStart, reset pulse, input change
    task automatic run_line(input logic [9:0] yn, input logic [19:0] sy, input logic [1:0] en,
                            input int ls2, input int rstc, input int chgc, input int ncyc);
        @(posedge CLK); #1;
        YNext = yn; SprY = sy; SprEn = en; LineStart = 1'b1;
        record(0);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge CLK); #1;
            LineStart = (k == ls2);
            Rst_n = (k != rstc);
            if (k == chgc) begin
                YNext = 10'd500; SprY = {10'd7, 10'd300}; SprEn = 2'b00;
            end
            record(k);
        end
        LineStart = 1'b0;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            LineStart = (k == 1);
        end
        LineStart = 1'b0;
        checks++;
        if ({MemReq, MemSel, MemAddr, Busy, Done, Overrun, RowValid, RowBits} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b sel=%0d addr=%0d busy=%b done=%b ovr=%b rv=%b rb=%h exp all zero",
                     MemReq, MemSel, MemAddr, Busy, Done, Overrun, RowValid, RowBits);
        end
        Rst_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_linestart got busy=%b exp 0", Busy);
        end
    endtask

    task automatic test_two_hits;
        logic e_req, e_done; logic [2:0] e_sel; logic [6:0] e_addr;
        run_line(10'd125, {10'd120, 10'd100}, 2'b11, -1, -1, -1, 14);
        for (int k = 1; k <= 14; k++) begin
            e_req  = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
            e_sel  = (k >= 7 && k <= 10) ? 3'd1 : 3'd0;
            e_addr = (k >= 2 && k <= 5) ? 7'(98 + k) : (k >= 7 && k <= 10) ? 7'(13 + k) : 7'd0;
            e_done = (k == 12);
            checks++;
            if ({tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], tr_ovr[k], tr_busy[k]} !==
                {e_req, e_sel, e_addr, e_done, 1'b0, (k <= 11)}) begin
                errors++;
                $display("FAIL two_hits cyc=%0d got req/sel/addr/done/ovr/busy=%b/%0d/%0d/%b/%b/%b exp=%b/%0d/%0d/%b/0/%b",
                         k, tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], tr_ovr[k], tr_busy[k],
                         e_req, e_sel, e_addr, e_done, (k <= 11));
            end
        end
        checks++;
        if (tr_rv[11] !== 2'b00 || tr_rb[11] !== 64'd0) begin
            errors++;
            $display("FAIL two_hits_precommit got rv=%b rb=%h exp rv=00 rb=0", tr_rv[11], tr_rb[11]);
        end
        checks++;
        if (tr_rv[12] !== 2'b11 || tr_rb[12] !== {exp_row(3'd1, 7'd20), exp_row(3'd0, 7'd100)}) begin
            errors++;
            $display("FAIL two_hits_commit got rv=%b rb=%h exp rv=11 rb=%h", tr_rv[12], tr_rb[12],
                     {exp_row(3'd1, 7'd20), exp_row(3'd0, 7'd100)});
        end
        checks++;
        if (tr_rb[14] !== {exp_row(3'd1, 7'd20), exp_row(3'd0, 7'd100)}) begin
            errors++;
            $display("FAIL two_hits_stable got rb=%h exp %h", tr_rb[14], {exp_row(3'd1, 7'd20), exp_row(3'd0, 7'd100)});
        end
    endtask

    task automatic test_miss;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) run_line(10'd125, {10'd120, 10'd100}, 2'b00, -1, -1, -1, 6);
            else        run_line(10'd99,  {10'd200, 10'd100}, 2'b11, -1, -1, -1, 6);
            for (int k = 1; k <= 6; k++) begin
                checks++;
                if (tr_req[k] !== 1'b0 || tr_done[k] !== (k == 4)) begin
                    errors++;
                    $display("FAIL miss case=%0d cyc=%0d got req=%b done=%b exp req=0 done=%b",
                             c, k, tr_req[k], tr_done[k], (k == 4));
                end
            end
            checks++;
            if (tr_rv[4] !== 2'b00 || tr_rb[4] !== 64'd0) begin
                errors++;
                $display("FAIL miss_commit case=%0d got rv=%b rb=%h exp rv=00 rb=0", c, tr_rv[4], tr_rb[4]);
            end
        end
    endtask

    task automatic test_wrap;
        logic e_req; logic [6:0] e_addr;
        // ys = 5 - 1000 mod 1024 = 29
        run_line(10'd5, {10'd0, 10'd1000}, 2'b01, -1, -1, -1, 9);
        for (int k = 1; k <= 9; k++) begin
            e_req  = (k >= 2 && k <= 5);
            e_addr = e_req ? 7'(114 + k) : 7'd0;
            checks++;
            if ({tr_req[k], tr_sel[k], tr_addr[k], tr_done[k]} !== {e_req, 3'd0, e_addr, (k == 8)}) begin
                errors++;
                $display("FAIL wrap cyc=%0d got req/sel/addr/done=%b/%0d/%0d/%b exp=%b/0/%0d/%b",
                         k, tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], e_req, e_addr, (k == 8));
            end
        end
        checks++;
        if (tr_rv[8] !== 2'b01 || tr_rb[8] !== {32'd0, exp_row(3'd0, 7'd116)}) begin
            errors++;
            $display("FAIL wrap_commit got rv=%b rb=%h exp rv=01 rb=%h", tr_rv[8], tr_rb[8], {32'd0, exp_row(3'd0, 7'd116)});
        end
        // sprite 0: ys=32 miss; sprite 1: ys=31 hit (last row)
        run_line(10'd37, {10'd6, 10'd5}, 2'b11, -1, -1, -1, 9);
        for (int k = 1; k <= 9; k++) begin
            e_req  = (k >= 3 && k <= 6);
            e_addr = e_req ? 7'(121 + k) : 7'd0;
            checks++;
            if ({tr_req[k], tr_sel[k], tr_addr[k], tr_done[k]} !== {e_req, e_req ? 3'd1 : 3'd0, e_addr, (k == 8)}) begin
                errors++;
                $display("FAIL boundary cyc=%0d got req/sel/addr/done=%b/%0d/%0d/%b exp=%b/%0d/%0d/%b",
                         k, tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], e_req, e_req ? 1 : 0, e_addr, (k == 8));
            end
        end
        checks++;
        if (tr_rv[8] !== 2'b10 || tr_rb[8] !== {exp_row(3'd1, 7'd124), 32'd0}) begin
            errors++;
            $display("FAIL boundary_commit got rv=%b rb=%h exp rv=10 rb=%h", tr_rv[8], tr_rb[8], {exp_row(3'd1, 7'd124), 32'd0});
        end
    endtask

    task automatic test_overrun;
        logic e_req; logic [2:0] e_sel; logic [6:0] e_addr;
        run_line(10'd125, {10'd120, 10'd100}, 2'b11, 6, -1, -1, 20);
        for (int k = 1; k <= 20; k++) begin
            e_req  = (k >= 2 && k <= 5) || (k >= 8 && k <= 11) || (k >= 13 && k <= 16);
            e_sel  = (k >= 13 && k <= 16) ? 3'd1 : 3'd0;
            e_addr = (k >= 2 && k <= 5) ? 7'(98 + k) : (k >= 8 && k <= 11) ? 7'(92 + k) :
                     (k >= 13 && k <= 16) ? 7'(7 + k) : 7'd0;
            checks++;
            if ({tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], tr_ovr[k]} !==
                {e_req, e_sel, e_addr, (k == 18), (k == 7)}) begin
                errors++;
                $display("FAIL overrun cyc=%0d got req/sel/addr/done/ovr=%b/%0d/%0d/%b/%b exp=%b/%0d/%0d/%b/%b",
                         k, tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], tr_ovr[k],
                         e_req, e_sel, e_addr, (k == 18), (k == 7));
            end
        end
        checks++;
        if (tr_rv[18] !== 2'b11 || tr_rb[18] !== {exp_row(3'd1, 7'd20), exp_row(3'd0, 7'd100)}) begin
            errors++;
            $display("FAIL overrun_commit got rv=%b rb=%h exp rv=11 rb=%h", tr_rv[18], tr_rb[18],
                     {exp_row(3'd1, 7'd20), exp_row(3'd0, 7'd100)});
        end
    endtask

    task automatic test_latch;
        logic e_req; logic [2:0] e_sel; logic [6:0] e_addr;
        run_line(10'd125, {10'd120, 10'd100}, 2'b11, -1, -1, 3, 13);
        for (int k = 1; k <= 13; k++) begin
            e_req  = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
            e_sel  = (k >= 7 && k <= 10) ? 3'd1 : 3'd0;
            e_addr = (k >= 2 && k <= 5) ? 7'(98 + k) : (k >= 7 && k <= 10) ? 7'(13 + k) : 7'd0;
            checks++;
            if ({tr_req[k], tr_sel[k], tr_addr[k], tr_done[k]} !== {e_req, e_sel, e_addr, (k == 12)}) begin
                errors++;
                $display("FAIL latch cyc=%0d got req/sel/addr/done=%b/%0d/%0d/%b exp=%b/%0d/%0d/%b",
                         k, tr_req[k], tr_sel[k], tr_addr[k], tr_done[k], e_req, e_sel, e_addr, (k == 12));
            end
        end
        checks++;
        if (tr_rv[12] !== 2'b11) begin
            errors++;
            $display("FAIL latch_valid got rv=%b exp 11", tr_rv[12]);
        end
    endtask

    task automatic test_back_to_back;
        logic e_req; logic [2:0] e_sel;
        run_line(10'd125, {10'd120, 10'd100}, 2'b11, 12, -1, -1, 26);
        for (int k = 1; k <= 26; k++) begin
            e_req = (k >= 2 && k <= 5) || (k >= 7 && k <= 10) || (k >= 14 && k <= 17) || (k >= 19 && k <= 22);
            e_sel = ((k >= 7 && k <= 10) || (k >= 19 && k <= 22)) ? 3'd1 : 3'd0;
            checks++;
            if ({tr_req[k], tr_sel[k], tr_done[k], tr_ovr[k]} !== {e_req, e_sel, (k == 12 || k == 24), 1'b0}) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got req/sel/done/ovr=%b/%0d/%b/%b exp=%b/%0d/%b/0",
                         k, tr_req[k], tr_sel[k], tr_done[k], tr_ovr[k], e_req, e_sel, (k == 12 || k == 24));
            end
        end
    endtask

    task automatic test_reset_mid;
        run_line(10'd125, {10'd120, 10'd100}, 2'b11, -1, 3, -1, 16);
        checks++;
        if ({tr_req[4], tr_sel[4], tr_addr[4], tr_busy[4], tr_done[4], tr_ovr[4], tr_rv[4], tr_rb[4]} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got req=%b busy=%b done=%b rv=%b rb=%h exp all zero",
                     tr_req[4], tr_busy[4], tr_done[4], tr_rv[4], tr_rb[4]);
        end
        for (int k = 4; k <= 16; k++) begin
            checks++;
            if (tr_done[k] !== 1'b0 || tr_req[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet cyc=%0d got done=%b req=%b exp 0/0", k, tr_done[k], tr_req[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_hits();
        test_miss();
        test_wrap();
        test_overrun();
        test_latch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_sched.md
SPRITE_FETCH_SCHED -- requirements
Module: sprite_fetch_sched

Interface
REQ-001 SHALL have parameter NSPR, default 2, meaning number of sprites served (legal 1..8).
REQ-002 SHALL have parameter ROWS, default 32, meaning sprite height in lines; sprite width is fixed at 32 px (4 bytes per row).
REQ-003 SHALL have port CLK  in  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port Rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port LineStart  in  1  one-cycle pulse at start of horizontal blank.
REQ-006 SHALL have port YNext  in  10  scanline about to be displayed.
REQ-007 SHALL have port SprY  in  10*NSPR  top line per sprite; sprite i in bits [10i+9:10i].
REQ-008 SHALL have port SprEn  in  NSPR  per-sprite enable.
REQ-009 SHALL have port MemReq  out  1  shared bitmap memory read strobe.
REQ-010 SHALL have port MemSel  out  3  sprite index selecting the bitmap bank.
REQ-011 SHALL have port MemAddr  out  7  byte address = row*4 + word.
REQ-012 SHALL have port MemData  in  8  read data, valid exactly one cycle after MemReq.
REQ-013 SHALL have port RowBits  out  32*NSPR  committed row per sprite; bit 31 = leftmost pixel.
REQ-014 SHALL have port RowValid  out  NSPR  sprite i covers the committed line.
REQ-015 SHALL have ports Busy, Done, Overrun  out  1 each  status flags.

Function
REQ-016 SHALL implement states IDLE, CHECK, FETCH, DRAIN; IDLE -> CHECK on LineStart.
REQ-017 SHALL latch YNext, SprY and SprEn in the LineStart cycle; later changes SHALL NOT affect the current line.
REQ-018 CHECK for sprite i: ys = YNext - SprY[i] as 10-bit modulo; hit = SprEn[i] and ys < ROWS; one cycle.
REQ-019 On hit: SHALL go to FETCH for 4 cycles with MemReq=1, MemSel=i, MemAddr=ys[6:0]*4 + w for w = 0,1,2,3 in order.
REQ-020 On miss: SHALL clear shadow row i to 0 and shadow valid i to 0, with no MemReq.
REQ-021 Each MemData byte SHALL be captured one cycle after its request; word w goes to shadow bits [31-8w:24-8w].
REQ-022 After sprite i, SHALL go to CHECK i+1; after sprite NSPR-1, SHALL go to DRAIN for one cycle, then IDLE.
REQ-023 On leaving DRAIN, SHALL copy all shadow rows and valids to RowBits/RowValid atomically and pulse Done for one cycle. New values SHALL be visible in the Done cycle.
REQ-024 RowBits/RowValid SHALL be stable between commits.
REQ-025 Busy SHALL be 1 in CHECK, FETCH and DRAIN, and 0 in IDLE.
REQ-026 Latency: LineStart in cycle 0 -> Done in cycle 2 + NSPR + 4*(number of hits).
REQ-027 LineStart while Busy (any state, including DRAIN): SHALL abort without commit and without Done, pulse Overrun for one cycle, relatch inputs, and go to CHECK of sprite 0 next cycle. Any capture pending from the aborted line SHALL be discarded.
REQ-028 LineStart in the same cycle as Done (state IDLE) SHALL be a normal start with no Overrun.
REQ-029 MemReq SHALL be 0 outside FETCH; MemSel/MemAddr SHALL be 0 when MemReq=0.
REQ-030 Unused MemSel upper bits SHALL be 0.

Reset
REQ-031 With Rst_n=0 at a clock edge: state IDLE; RowBits=0, RowValid=0, shadows=0, MemReq=0, Busy=0, Done=0, Overrun=0.
REQ-032 Reset mid-fetch SHALL discard the line; no Done SHALL follow.
REQ-033 LineStart SHALL be ignored while Rst_n=0.

Verification
REQ-034 Case: NSPR=2; SprY=100 and 120, both enabled; YNext=125; LineStart.
  - MemReq in cycles 2-5 with Sel 0, Addr 100..103.
  - MemReq in cycles 7-10 with Sel 1, Addr 20..23.
  - Done in cycle 12; RowValid=2'b11; RowBits match memory bytes.
REQ-035 Case: SprEn=0, or YNext=99 with SprY=100.
  - No MemReq.
  - Done in cycle 4; RowValid=0; RowBits=0.
REQ-036 Case: SprY=1000, YNext=5 (ys=29 after wrap).
  - Hit; Addr 116..119.
  - Case: SprY=5, YNext=37 (ys=32): miss.
REQ-037 Case: second LineStart in cycle 6 of REQ-034.
  - Overrun in cycle 7; no Done in cycle 12.
  - Restart fetch from sprite 0; Done in cycle 18.
REQ-038 Case: Rst_n=0 in cycle 3 of REQ-034.
  - All outputs 0 next cycle; no Done.
  - Prior RowBits cleared.
REQ-039 Case: change YNext/SprY in cycle 3.
  - Fetched addresses unchanged versus REQ-034.
